sram_synaptic_rmw: RTL and testbench

Parametrised synaptic weight memory for the FF-STDP core with an in-memory read-modify-write update port. Each word packs NUM_SYN signed weights. A host port gives plain synchronous read/write access for weight load and readout. A pipelined update port applies a signed, saturating delta to masked synapses of one word per cycle. After reset the array is cleared by an internal init sequencer, so no simulation-only preload is needed.

---
 rtl/sram_synaptic_rmw.sv | 213 +++++++++++++++++++++
 tb/tb_sram_synaptic_rmw.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_synaptic_rmw.sv
// Synaptic weight memory with a host read/write port and a two-stage
// read-modify-write update port applying a saturating signed delta to
// masked weight lanes of one word per cycle. An init sequencer clears
// the array after reset.
module sram_synaptic_rmw #(
    parameter int ADDR_WIDTH  = 8,
    parameter int SRAM_DEPTH  = 256,
    parameter int NUM_SYN     = 4,
    parameter int W_WIDTH     = 8,
    parameter int DELTA_WIDTH = 8,
    parameter int INIT_CLEAR  = 1,
    localparam int DATA_WIDTH = NUM_SYN * W_WIDTH
) (
    input  logic                   ck,
    input  logic                   rstn,
    input  logic                   cs,
    input  logic                   we,
    input  logic [ADDR_WIDTH-1:0]  a,
    input  logic [DATA_WIDTH-1:0]  d,
    output logic [DATA_WIDTH-1:0]  q,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [ADDR_WIDTH-1:0]  upd_addr,
    input  logic [NUM_SYN-1:0]     upd_mask,
    input  logic [DELTA_WIDTH-1:0] upd_delta,
    output logic                   upd_done,
    output logic                   upd_sat,
    output logic                   init_done
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SRAM_DEPTH - 1);
    // One guard bit beyond W_WIDTH+1 keeps a full-range (W_WIDTH+1)-bit delta from wrapping.
    localparam logic signed [W_WIDTH+1:0] SUM_MAX = (W_WIDTH+2)'(2**(W_WIDTH-1) - 1);
    localparam logic signed [W_WIDTH+1:0] SUM_MIN = (W_WIDTH+2)'(-(2**(W_WIDTH-1)));
    localparam logic [W_WIDTH-1:0] SAT_HI = {1'b0, {(W_WIDTH-1){1'b1}}};
    localparam logic [W_WIDTH-1:0] SAT_LO = {1'b1, {(W_WIDTH-1){1'b0}}};

    state_t                  state, state_nx;
    logic                    run, init_wr;
    logic [ADDR_WIDTH-1:0]   init_addr;

    logic [DATA_WIDTH-1:0]   mem [SRAM_DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    logic                    host_rd, host_wr, accept;

    // Stage 1 (compute/commit) registers
    logic                    s1_valid;
    logic [ADDR_WIDTH-1:0]   s1_addr;
    logic [NUM_SYN-1:0]      s1_mask;
    logic [DELTA_WIDTH-1:0]  s1_delta;
    logic [DATA_WIDTH-1:0]   s1_rd;
    logic                    s1_fwd;
    logic [DATA_WIDTH-1:0]   s1_fwd_data;
    logic [DATA_WIDTH-1:0]   s1_base, s1_new;
    logic                    s1_sat;

    // Commit that lost the write port to a host write
    logic                    pend_valid;
    logic [ADDR_WIDTH-1:0]   pend_addr;
    logic [DATA_WIDTH-1:0]   pend_data;
    logic                    pend_sat;

    logic                    commit_req, commit_fire, commit_sat;
    logic [ADDR_WIDTH-1:0]   commit_addr;
    logic [DATA_WIDTH-1:0]   commit_data;

    logic [W_WIDTH-1:0]      lane_w, lane_res;
    logic [W_WIDTH+1:0]      sum;

    // FSM state register
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) state <= ST_INIT;
        else       state <= state_nx;
    end

    // FSM next state: leave INIT after the last clear write (or at once when clearing is off)
    always_comb begin
        state_nx = state;
        if (state == ST_INIT && (INIT_CLEAR == 0 || init_addr == LAST_ADDR))
            state_nx = ST_RUN;
    end

    // FSM outputs
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        run     = 1'b0;
        init_wr = 1'b0;
        case (state)
            ST_INIT: init_wr = (INIT_CLEAR != 0);
            ST_RUN:  run     = 1'b1;
        endcase
    end

    assign init_done  = run;
    assign host_rd    = run & cs;
    assign host_wr    = run & cs & we;
    assign upd_ready  = run & ~cs & ~pend_valid;
    assign accept     = upd_valid & upd_ready;
    assign rd_addr    = cs ? a : upd_addr;

    assign commit_req  = s1_valid | pend_valid;
    assign commit_fire = commit_req & ~host_wr;
    assign commit_addr = pend_valid ? pend_addr : s1_addr;
    assign commit_data = pend_valid ? pend_data : s1_new;
    assign commit_sat  = pend_valid ? pend_sat  : s1_sat;

    assign s1_base = s1_fwd ? s1_fwd_data : s1_rd;

    // Per-lane saturating add of the delta on masked lanes
    always_comb begin
        s1_new   = '0;
        s1_sat   = 1'b0;
        lane_w   = '0;
        lane_res = '0;
        sum      = '0;
        for (int i = 0; i < NUM_SYN; i++) begin
            lane_w   = s1_base[i*W_WIDTH +: W_WIDTH];
            sum      = {{2{lane_w[W_WIDTH-1]}}, lane_w}
                     + {{(W_WIDTH+2-DELTA_WIDTH){s1_delta[DELTA_WIDTH-1]}}, s1_delta};
            lane_res = lane_w;
            if (s1_mask[i]) begin
                if ($signed(sum) > SUM_MAX) begin
                    lane_res = SAT_HI;
                    s1_sat   = 1'b1;
                end else if ($signed(sum) < SUM_MIN) begin
                    lane_res = SAT_LO;
                    s1_sat   = 1'b1;
                end else begin
                    lane_res = sum[W_WIDTH-1:0];
                end
            end
            s1_new[i*W_WIDTH +: W_WIDTH] = lane_res;
        end
    end

    // Write-port arbitration: init clear, then host write, then update commit
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (init_wr) begin
            mem_we    = 1'b1;
            mem_waddr = init_addr;
        end else if (host_wr) begin
            mem_we    = 1'b1;
            mem_waddr = a;
            mem_wdata = d;
        end else if (commit_fire) begin
            mem_we    = 1'b1;
            mem_waddr = commit_addr;
            mem_wdata = commit_data;
        end
    end

    // Storage array write port
    // NOTE: the array itself has no reset; clearing is done by the init sequencer.
    always_ff @(posedge ck) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Init address counter
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn)        init_addr <= '0;
        else if (init_wr) init_addr <= init_addr + ADDR_WIDTH'(1);
    end

    // Read port, update pipeline, pending commit and status pulses
    always_ff @(posedge ck or negedge rstn) begin
        if (!rstn) begin
            q           <= '0;
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            s1_mask     <= '0;
            s1_delta    <= '0;
            s1_rd       <= '0;
            s1_fwd      <= 1'b0;
            s1_fwd_data <= '0;
            pend_valid  <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            pend_sat    <= 1'b0;
            upd_done    <= 1'b0;
            upd_sat     <= 1'b0;
        end else begin
            if (host_rd) q <= mem[rd_addr];
            s1_valid <= accept;
            if (accept) begin
                s1_addr     <= upd_addr;
                s1_mask     <= upd_mask;
                s1_delta    <= upd_delta;
                s1_rd       <= mem[rd_addr];
                s1_fwd      <= commit_fire && (commit_addr == upd_addr);
                s1_fwd_data <= commit_data;
            end
            pend_valid <= commit_req & host_wr;
            if (commit_req & host_wr) begin
                pend_addr <= commit_addr;
                pend_data <= commit_data;
                pend_sat  <= commit_sat;
            end
            upd_done <= commit_fire;
            upd_sat  <= commit_fire & commit_sat;
        end
    end

endmodule

// File: tb/tb_sram_synaptic_rmw.sv
// Self-checking bench for sram_synaptic_rmw: directed scenarios plus a
// randomized mix of host and update traffic against an array model.
module tb_sram_synaptic_rmw;

    logic        ck = 1'b0;
    logic        rstn;
    logic        cs, we;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] q;
    logic        upd_valid, upd_ready;
    logic [7:0]  upd_addr;
    logic [3:0]  upd_mask;
    logic [7:0]  upd_delta;
    logic        upd_done, upd_sat, init_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_mem [256];
    bit          exp_sat_q [$];

    sram_synaptic_rmw #(
        .ADDR_WIDTH(8), .SRAM_DEPTH(256), .NUM_SYN(4),
        .W_WIDTH(8), .DELTA_WIDTH(8), .INIT_CLEAR(1)
    ) dut (
        .ck(ck), .rstn(rstn), .cs(cs), .we(we), .a(a), .d(d), .q(q),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_addr(upd_addr),
        .upd_mask(upd_mask), .upd_delta(upd_delta), .upd_done(upd_done),
        .upd_sat(upd_sat), .init_done(init_done)
    );

    always #5 ck = ~ck;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference rule: each masked lane gets weight+delta clipped to [-128,127].
    function automatic void apply_upd(input logic [31:0] w, input logic [3:0] m,
                                      input logic [7:0] dl,
                                      output logic [31:0] r, output logic s);
        int lane, sum;
        r = w;
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                lane = int'($signed(w[i*8 +: 8]));
                sum  = lane + int'($signed(dl));
                if (sum > 127)  begin sum = 127;  s = 1'b1; end
                if (sum < -128) begin sum = -128; s = 1'b1; end
                r[i*8 +: 8] = 8'(sum);
            end
        end
    endfunction

    task automatic tick;
        @(posedge ck);
        #1;
    endtask

    task automatic host_op(input logic [7:0] addr, input logic wr, input logic [31:0] data);
        cs = 1'b1; we = wr; a = addr; d = data; upd_valid = 1'b0;
        tick;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic host_write(input logic [7:0] addr, input logic [31:0] data);
        host_op(addr, 1'b1, data);
        model_mem[addr] = data;
    endtask

    task automatic host_read(input string tag, input logic [7:0] addr);
        host_op(addr, 1'b0, '0);
        check(tag, q, model_mem[addr]);
    endtask

    task automatic consume_done;
        if (upd_done) begin
            if (exp_sat_q.size() == 0) check("done_unexpected", upd_done, 1'b0);
            else                       check("rand_sat", upd_sat, exp_sat_q.pop_front());
        end
    endtask

    // Wait for init with an update request held valid; it must never be accepted.
    task automatic wait_init;
        int k_done = 0;
        int ready_hi = 0;
        upd_valid = 1'b1; upd_addr = 8'd0; upd_mask = 4'hF; upd_delta = 8'd1;
        for (int k = 1; k <= 300; k++) begin
            tick;
            if (!init_done && upd_ready) ready_hi++;
            if (init_done) begin
                k_done = k;
                break;
            end
        end
        upd_valid = 1'b0;
        check("init_cycles", k_done, 256);
        check("ready_in_init", ready_hi, 0);
        for (int i = 0; i < 256; i++) model_mem[i] = '0;
    endtask

    task automatic start_upd(input logic [7:0] addr, input logic [3:0] m, input logic [7:0] dl);
        logic [31:0] r;
        logic        s;
        upd_valid = 1'b1; upd_addr = addr; upd_mask = m; upd_delta = dl; cs = 1'b0;
        apply_upd(model_mem[addr], m, dl, r, s);
        model_mem[addr] = r;
    endtask

    function automatic bit sat_of(input logic [31:0] w, input logic [3:0] m, input logic [7:0] dl);
        logic [31:0] r;
        logic        s;
        apply_upd(w, m, dl, r, s);
        return s;
    endfunction

    initial begin
        logic [31:0] exp_q, old;
        bit          host, s;
        logic [31:0] r;

        rstn = 1'b0; cs = 1'b0; we = 1'b0; a = '0; d = '0;
        upd_valid = 1'b0; upd_addr = '0; upd_mask = '0; upd_delta = '0;
        tick; tick;
        check("rst_q", q, 32'h0);
        check("rst_ready", upd_ready, 1'b0);
        check("rst_done", upd_done, 1'b0);
        check("rst_sat", upd_sat, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        rstn = 1'b1;

        // Init clears the array
        wait_init;
        host_read("init_rd0", 8'd0);
        host_read("init_rd255", 8'd255);

        // Host write / read-back
        host_write(8'd5, 32'h7F80_0102);
        host_read("host_rd5", 8'd5);
        check("host_rd5_const", q, 32'h7F80_0102);

        // Saturating update +2: lane 3 clips at 0x7F
        s = sat_of(model_mem[5], 4'hF, 8'd2);
        start_upd(8'd5, 4'hF, 8'd2);
        #1 check("upd_ready_idle", upd_ready, 1'b1);
        tick; upd_valid = 1'b0;
        check("upd_done_n", upd_done, 1'b0);
        tick;
        check("upd_done_n1", upd_done, 1'b1);
        check("upd_sat_plus", upd_sat, s);
        tick;
        check("upd_done_pulse", upd_done, 1'b0);
        host_read("upd_plus_word", 8'd5);
        check("upd_plus_const", q, 32'h7F82_0304);

        // Update -4 on the original word: lane 2 clips at 0x80, lane 1 = 1-4 = 0xFD
        host_write(8'd5, 32'h7F80_0102);
        s = sat_of(model_mem[5], 4'hF, 8'hFC);
        start_upd(8'd5, 4'hF, 8'hFC);
        tick; upd_valid = 1'b0;
        tick;
        check("upd_done_minus", upd_done, 1'b1);
        check("upd_sat_minus", upd_sat, s);
        host_read("upd_minus_word", 8'd5);

        // Three back-to-back updates accumulate through forwarding
        host_write(8'd9, 32'h0);
        for (int j = 0; j < 3; j++) begin
            start_upd(8'd9, 4'b0001, 8'd1);
            #1 check("b2b_ready", upd_ready, 1'b1);
            tick;
            check("b2b_done", upd_done, (j == 0) ? 1'b0 : 1'b1);
        end
        upd_valid = 1'b0;
        tick; check("b2b_done3", upd_done, 1'b1);
        tick; check("b2b_done_end", upd_done, 1'b0);
        host_read("b2b_word", 8'd9);
        check("b2b_const", q, 32'h0000_0003);

        // Commit collides with a host write: commit is held one cycle
        host_write(8'd7, 32'h0102_7F80);
        s = sat_of(model_mem[7], 4'b0101, 8'h10);
        start_upd(8'd7, 4'b0101, 8'h10);
        tick;
        upd_valid = 1'b0;
        cs = 1'b1; we = 1'b1; a = 8'd3; d = 32'hA5A5_5A5A;
        model_mem[3] = 32'hA5A5_5A5A;
        tick;
        cs = 1'b0; we = 1'b0;
        check("coll_done_held", upd_done, 1'b0);
        #1 check("coll_ready_pending", upd_ready, 1'b0);
        tick;
        check("coll_done_late", upd_done, 1'b1);
        check("coll_sat", upd_sat, s);
        tick;
        check("coll_done_pulse", upd_done, 1'b0);
        host_read("coll_host_word", 8'd3);
        host_read("coll_upd_word", 8'd7);

        // Randomized traffic: host ops on 0..127, updates on 128..135
        for (int i = 128; i < 136; i++) host_write(8'(i), $urandom);
        for (int cyc = 0; cyc < 600; cyc++) begin
            host = ($urandom_range(0, 3) == 0);
            if (host) begin
                cs = 1'b1; we = 1'($urandom_range(0, 1));
                a = 8'($urandom_range(0, 127)); d = $urandom; upd_valid = 1'b0;
            end else begin
                cs = 1'b0; we = 1'b0;
                upd_valid = ($urandom_range(0, 3) != 0);
                upd_addr  = 8'($urandom_range(128, 135));
                upd_mask  = 4'($urandom);
                upd_delta = 8'($urandom);
            end
            #1;
            if (host) check("rand_ready_cs", upd_ready, 1'b0);
            if (upd_valid && upd_ready) begin
                old = model_mem[upd_addr];
                apply_upd(old, upd_mask, upd_delta, r, s);
                model_mem[upd_addr] = r;
                exp_sat_q.push_back(s);
            end
            if (host) begin
                exp_q = model_mem[a];
                if (we) model_mem[a] = d;
            end
            tick;
            if (host) check("rand_q", q, exp_q);
            consume_done;
        end
        cs = 1'b0; we = 1'b0; upd_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            consume_done;
        end
        check("drain_queue", exp_sat_q.size(), 0);
        for (int i = 128; i < 136; i++) host_read("rand_upd_word", 8'(i));
        for (int i = 0; i < 16; i++) host_read("rand_host_word", 8'($urandom_range(0, 127)));

        // Reset while an update sits in S1
        host_write(8'd11, 32'h1122_3344);
        host_read("pre_rst_rd", 8'd11);
        start_upd(8'd11, 4'hF, 8'd1);
        tick;
        upd_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_q", q, 32'h0);
        check("mid_rst_ready", upd_ready, 1'b0);
        check("mid_rst_done", upd_done, 1'b0);
        check("mid_rst_sat", upd_sat, 1'b0);
        check("mid_rst_init_done", init_done, 1'b0);
        tick;
        check("mid_rst_no_done", upd_done, 1'b0);
        tick;
        rstn = 1'b1;
        wait_init;
        host_read("rerun_rd11", 8'd11);
        host_read("rerun_rd5", 8'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
